// File: rtl/comparator_pkg.sv
// Shared types and constants for the serial magnitude comparator.
package comparator_pkg;

    // Controller states: waiting for a request, or stepping through digits.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // One-hot result encoding, ordered {gt, eq, lt}.
    localparam logic [2:0] RES_GT   = 3'b100;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_LT   = 3'b001;
    localparam logic [2:0] RES_NONE = 3'b000;

    // Ceiling log2, used to size the digit counter.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/digit_comparator.sv
// Combinational DIGIT-bit magnitude compare built from per-bit
// A>B / A<B terms, cascaded from the most significant bit down.
module digit_comparator #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    output logic             gt_d,
    output logic             eq_d,
    output logic             lt_d
);

    logic [DIGIT-1:0] bit_gt;
    logic [DIGIT-1:0] bit_lt;
    logic             gt_r;
    logic             lt_r;

    assign bit_gt = a_d & ~b_d;
    assign bit_lt = ~a_d & b_d;

    // The first differing bit from the MSB decides; lower bits are ignored after that.
    always_comb begin
        gt_r = 1'b0;
        lt_r = 1'b0;
        for (int i = DIGIT - 1; i >= 0; i--) begin
            if (!gt_r && !lt_r) begin
                if (bit_gt[i]) begin
                    gt_r = 1'b1;
                end else if (bit_lt[i]) begin
                    lt_r = 1'b1;
                end
            end
        end
    end

    assign gt_d = gt_r;
    assign lt_d = lt_r;
    assign eq_d = ~(gt_r | lt_r);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle magnitude comparator: captures two operands on start and
// compares DIGIT bits per cycle, MSB first, stopping at the first
// differing digit. Signed compares flip the sign bit (offset binary).
//
// Handshake: start is sampled only while busy=0. An accepted start raises
// busy on the same edge; busy falls on the edge that raises done, and done
// is a one-cycle pulse. A start seen during the done cycle is accepted, so
// results can be issued back to back. {gt,eq,lt} hold until the next done.
module serial_magnitude_comparator
    import comparator_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int KW   = (NDIG > 1) ? clog2(NDIG) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NDIG - 1);

    state_t           state;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sign_q;
    logic             busy_q;
    logic             done_q;
    logic [2:0]       res_q;

    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic             gt_d;
    logic             eq_d;
    logic             lt_d;

    // Current digit sits at the top of the shift registers; the sign flip
    // only applies to the first digit, which holds the operand MSBs.
    always_comb begin
        a_dig = a_q[WIDTH-1 -: DIGIT];
        b_dig = b_q[WIDTH-1 -: DIGIT];
        if (sign_q && (k == '0)) begin
            a_dig[DIGIT-1] = ~a_dig[DIGIT-1];
            b_dig[DIGIT-1] = ~b_dig[DIGIT-1];
        end
    end

    digit_comparator #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a_d  (a_dig),
        .b_d  (b_dig),
        .gt_d (gt_d),
        .eq_d (eq_d),
        .lt_d (lt_d)
    );

    // Controller: capture on start, step digits, latch result and pulse done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            k      <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sign_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            res_q  <= RES_NONE;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        sign_q <= signed_mode;
                        k      <= '0;
                        busy_q <= 1'b1;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (gt_d) begin
                        res_q  <= RES_GT;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (lt_d) begin
                        res_q  <= RES_LT;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (eq_d && (k == K_LAST)) begin
                        res_q  <= RES_EQ;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        k   <= k + KW'(1);
                        a_q <= a_q << DIGIT;
                        b_q <= b_q << DIGIT;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign gt   = res_q[2];
    assign eq   = res_q[1];
    assign lt   = res_q[0];

endmodule
